// File: rtl/escalonador_round_robin_if.sv
// -----------------------------------------------------------------------------
// escalonador_round_robin_if
// Context-switch handshake between the round-robin scheduler and the CPU.
//   switch_req  : scheduler -> CPU, a dispatch is pending
//   next_pid    : scheduler -> CPU, process to dispatch (stable while switch_req)
//   next_pc     : scheduler -> CPU, resume PC of next_pid (stable while switch_req)
//   switch_ack  : CPU -> scheduler, next_pc has been loaded
// Modports: master = scheduler side, slave = CPU side.
// -----------------------------------------------------------------------------
interface escalonador_round_robin_if #(
    parameter int PID_W = 3,
    parameter int PC_W  = 32
);
    logic             switch_req;
    logic [PID_W-1:0] next_pid;
    logic [PC_W-1:0]  next_pc;
    logic             switch_ack;

    modport master (
        output switch_req,
        output next_pid,
        output next_pc,
        input  switch_ack
    );

    modport slave (
        input  switch_req,
        input  next_pid,
        input  next_pc,
        output switch_ack
    );
endinterface

// File: rtl/escalonador_round_robin.sv
// -----------------------------------------------------------------------------
// escalonador_round_robin
// Round-robin process scheduler. Holds a process table (state + saved PC per
// slot), counts retired instructions against a quantum, blocks processes on IN
// and wakes them on I/O completion, and requests context switches from the CPU
// over a req/ack handshake.
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   instr_retired_i   : one pulse per completed user instruction
//   cur_pc_i          : PC of running process, captured in SAVE
//   proc_create_i     : create slot create_pid_i at create_pc_i (if FREE)
//   proc_end_i        : running process finished
//   io_block_i        : running process issued IN
//   io_done_i/io_pid_i: wake blocked process io_pid_i
//   sw_if (master)    : switch_req / next_pid / next_pc / switch_ack
//   cur_pid_o         : running process
//   idle_o            : no process running
//   ready_mask_o      : bit i set when slot i is READY
//
// Optional: define ESCALONADOR_STATS_EN to add saturating 16-bit
// switch_count_o (accepted acks) and expiry_count_o (quantum expiries).
// -----------------------------------------------------------------------------
module escalonador_round_robin #(
    parameter int NUM_PROC = 8,
    parameter int PID_W    = 3,
    parameter int QUANTUM  = 16,
    parameter int PC_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_retired_i,
    input  logic [PC_W-1:0]       cur_pc_i,
    input  logic                  proc_create_i,
    input  logic [PID_W-1:0]      create_pid_i,
    input  logic [PC_W-1:0]       create_pc_i,
    input  logic                  proc_end_i,
    input  logic                  io_block_i,
    input  logic                  io_done_i,
    input  logic [PID_W-1:0]      io_pid_i,
    escalonador_round_robin_if.master sw_if,
    output logic [PID_W-1:0]      cur_pid_o,
    output logic                  idle_o,
    output logic [NUM_PROC-1:0]   ready_mask_o
`ifdef ESCALONADOR_STATS_EN
   ,output logic [15:0]           switch_count_o,
    output logic [15:0]           expiry_count_o
`endif
);

    localparam int CNT_W = $clog2(QUANTUM);

    typedef enum logic [1:0] {SLOT_FREE, SLOT_READY, SLOT_RUNNING, SLOT_BLOCKED} slot_t;
    typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_SAVE, ST_SELECT, ST_REQ} state_t;

    state_t             state_q;
    slot_t              slot_q [NUM_PROC];
    slot_t              slot_d [NUM_PROC];
    logic [PC_W-1:0]    pc_q   [NUM_PROC];
    logic [PC_W-1:0]    pc_d   [NUM_PROC];
    logic [NUM_PROC-1:0] mask_d;
    logic [NUM_PROC-1:0] ready_mask_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PID_W-1:0]   cur_pid_q;
    logic [PID_W-1:0]   next_pid_q;
    logic [PC_W-1:0]    next_pc_q;
    logic               switch_req_q;
    logic               idle_q;
    logic               save_block_q;

    logic               run_end, run_block, run_expiry, ack_take;
    logic               found;
    logic [PID_W-1:0]   sel_pid;
    logic [PID_W-1:0]   idx;

    // Event priority in RUN: proc_end > io_block > expiry.
    assign run_end    = (state_q == ST_RUN) && proc_end_i;
    assign run_block  = (state_q == ST_RUN) && !proc_end_i && io_block_i;
    assign run_expiry = (state_q == ST_RUN) && !proc_end_i && !io_block_i &&
                        instr_retired_i && (cnt_q == CNT_W'(QUANTUM - 1));
    assign ack_take   = (state_q == ST_REQ) && sw_if.switch_ack;

    // Table next state. External create/wake are applied first; the FSM's own
    // writes come later so they win (a wake racing the SAVE of a block is lost).
    always_comb begin
        for (int unsigned i = 0; i < NUM_PROC; i++) begin
            slot_d[i] = slot_q[i];
            pc_d[i]   = pc_q[i];
            if (proc_create_i && create_pid_i == PID_W'(i) && slot_q[i] == SLOT_FREE) begin
                slot_d[i] = SLOT_READY;
                pc_d[i]   = create_pc_i;
            end
            if (io_done_i && io_pid_i == PID_W'(i) && slot_q[i] == SLOT_BLOCKED)
                slot_d[i] = SLOT_READY;
        end
        if (run_end)
            slot_d[cur_pid_q] = SLOT_FREE;
        if (state_q == ST_SAVE) begin
            pc_d[cur_pid_q]   = cur_pc_i;
            slot_d[cur_pid_q] = save_block_q ? SLOT_BLOCKED : SLOT_READY;
        end
        if (ack_take)
            slot_d[next_pid_q] = SLOT_RUNNING;
    end

    always_comb begin
        mask_d = '0;
        for (int unsigned i = 0; i < NUM_PROC; i++)
            mask_d[i] = (slot_d[i] == SLOT_READY);
    end

    // Rotating search starting at cur_pid+1; k == NUM_PROC wraps to cur_pid,
    // so the current slot is considered last.
    always_comb begin
        found   = 1'b0;
        sel_pid = '0;
        idx     = '0;
        for (int unsigned k = 1; k <= NUM_PROC; k++) begin
            idx = cur_pid_q + PID_W'(k);
            if (!found && slot_q[idx] == SLOT_READY) begin
                found   = 1'b1;
                sel_pid = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            for (int unsigned i = 0; i < NUM_PROC; i++) begin
                slot_q[i] <= SLOT_FREE;
                pc_q[i]   <= '0;
            end
            ready_mask_q <= '0;
            cnt_q        <= '0;
            cur_pid_q    <= '0;
            next_pid_q   <= '0;
            next_pc_q    <= '0;
            switch_req_q <= 1'b0;
            idle_q       <= 1'b1;
            save_block_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            pc_q         <= pc_d;
            ready_mask_q <= mask_d;
            case (state_q)
                ST_IDLE: begin
                    idle_q <= 1'b1;
                    if (|ready_mask_q)
                        state_q <= ST_SELECT;
                end
                ST_RUN: begin
                    if (run_end) begin
                        state_q <= ST_SELECT;
                    end else if (run_block) begin
                        save_block_q <= 1'b1;
                        state_q      <= ST_SAVE;
                    end else if (run_expiry) begin
                        save_block_q <= 1'b0;
                        state_q      <= ST_SAVE;
                    end else if (instr_retired_i) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_SAVE: begin
                    state_q <= ST_SELECT;
                end
                ST_SELECT: begin
                    if (found) begin
                        next_pid_q   <= sel_pid;
                        next_pc_q    <= pc_q[sel_pid];
                        switch_req_q <= 1'b1;
                        state_q      <= ST_REQ;
                    end else begin
                        idle_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (sw_if.switch_ack) begin
                        cur_pid_q    <= next_pid_q;
                        cnt_q        <= '0;
                        switch_req_q <= 1'b0;
                        idle_q       <= 1'b0;
                        state_q      <= ST_RUN;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sw_if.switch_req = switch_req_q;
    assign sw_if.next_pid   = next_pid_q;
    assign sw_if.next_pc    = next_pc_q;
    assign cur_pid_o        = cur_pid_q;
    assign idle_o           = idle_q;
    assign ready_mask_o     = ready_mask_q;

`ifdef ESCALONADOR_STATS_EN
    logic [15:0] switch_count_q;
    logic [15:0] expiry_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            switch_count_q <= '0;
            expiry_count_q <= '0;
        end else begin
            if (ack_take && switch_count_q != '1)
                switch_count_q <= switch_count_q + 16'd1;
            if (run_expiry && expiry_count_q != '1)
                expiry_count_q <= expiry_count_q + 16'd1;
        end
    end

    assign switch_count_o = switch_count_q;
    assign expiry_count_o = expiry_count_q;
`endif

endmodule

// File: tb/tb_escalonador_round_robin.sv
module tb_escalonador_round_robin;

    localparam int NUM_PROC = 8;
    localparam int PID_W    = 3;
    localparam int QUANTUM  = 16;
    localparam int PC_W     = 32;

    logic                 clk;
    logic                 reset;
    logic                 instr_retired;
    logic [PC_W-1:0]      cur_pc;
    logic                 proc_create;
    logic [PID_W-1:0]     create_pid;
    logic [PC_W-1:0]      create_pc;
    logic                 proc_end;
    logic                 io_block;
    logic                 io_done;
    logic [PID_W-1:0]     io_pid;
    logic [PID_W-1:0]     cur_pid;
    logic                 idle;
    logic [NUM_PROC-1:0]  ready_mask;
`ifdef ESCALONADOR_STATS_EN
    logic [15:0]          switch_count;
    logic [15:0]          expiry_count;
`endif

    escalonador_round_robin_if #(.PID_W(PID_W), .PC_W(PC_W)) sw_if ();

    escalonador_round_robin #(
        .NUM_PROC (NUM_PROC),
        .PID_W    (PID_W),
        .QUANTUM  (QUANTUM),
        .PC_W     (PC_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_retired_i (instr_retired),
        .cur_pc_i        (cur_pc),
        .proc_create_i   (proc_create),
        .create_pid_i    (create_pid),
        .create_pc_i     (create_pc),
        .proc_end_i      (proc_end),
        .io_block_i      (io_block),
        .io_done_i       (io_done),
        .io_pid_i        (io_pid),
        .sw_if           (sw_if),
        .cur_pid_o       (cur_pid),
        .idle_o          (idle),
        .ready_mask_o    (ready_mask)
`ifdef ESCALONADOR_STATS_EN
       ,.switch_count_o  (switch_count),
        .expiry_count_o  (expiry_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [PID_W-1:0] pid;
        logic [PC_W-1:0]  pc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic req_seen = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every new switch request is checked against the scoreboard.
    always @(negedge clk) begin
        if (sw_if.switch_req && !req_seen) begin
            exp_t e;
            req_seen = 1'b1;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_req: got pid=%0d pc=0x%0h expected no request",
                         sw_if.next_pid, sw_if.next_pc);
            end else begin
                e = sb_q.pop_front();
                chk("sb_next_pid", 64'(sw_if.next_pid), 64'(e.pid));
                chk("sb_next_pc",  64'(sw_if.next_pc),  64'(e.pc));
            end
        end
        if (!sw_if.switch_req)
            req_seen = 1'b0;
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic expect_sw(int pid, logic [PC_W-1:0] pc);
        exp_t e;
        e.pid = PID_W'(pid);
        e.pc  = pc;
        sb_q.push_back(e);
    endtask

    task automatic create(int pid, logic [PC_W-1:0] pc);
        proc_create = 1'b1;
        create_pid  = PID_W'(pid);
        create_pc   = pc;
        step(1);
        proc_create = 1'b0;
    endtask

    task automatic retire(int n, logic [PC_W-1:0] pc);
        cur_pc = pc;
        repeat (n) begin
            instr_retired = 1'b1;
            step(1);
        end
        instr_retired = 1'b0;
    endtask

    task automatic wait_req(string name);
        int c = 0;
        while (!sw_if.switch_req && c < 20) begin
            step(1);
            c++;
        end
        chk(name, 64'(sw_if.switch_req), 64'd1);
    endtask

    task automatic ack();
        sw_if.switch_ack = 1'b1;
        step(1);
        sw_if.switch_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; instr_retired = 1'b0; cur_pc = '0;
        proc_create = 1'b0; create_pid = '0; create_pc = '0;
        proc_end = 1'b0; io_block = 1'b0; io_done = 1'b0; io_pid = '0;
        sw_if.switch_ack = 1'b0;
        step(2);
        chk("rst_switch_req", 64'(sw_if.switch_req), 64'd0);
        chk("rst_idle",       64'(idle),             64'd1);
        chk("rst_ready_mask", 64'(ready_mask),       64'd0);
        chk("rst_cur_pid",    64'(cur_pid),          64'd0);
        chk("rst_next_pid",   64'(sw_if.next_pid),   64'd0);
        chk("rst_next_pc",    64'(sw_if.next_pc),    64'd0);
        reset = 1'b0;
        step(1);

        // 1. Quantum expiry rotates between two processes
        expect_sw(1, 32'h100);
        create(1, 32'h100);
        create(2, 32'h200);
        wait_req("t1_req1");
        chk("t1_mask_req", 64'(ready_mask), 64'h06);
        ack();
        chk("t1_cur_pid1", 64'(cur_pid), 64'd1);
        chk("t1_idle0",    64'(idle), 64'd0);
        chk("t1_mask_run", 64'(ready_mask), 64'h04);
        expect_sw(2, 32'h200);
        retire(QUANTUM, 32'h110);
        chk("t1_lat_save",   64'(sw_if.switch_req), 64'd0);
        step(1);
        chk("t1_lat_select", 64'(sw_if.switch_req), 64'd0);
        step(1);
        chk("t1_lat_req",    64'(sw_if.switch_req), 64'd1);
        ack();
        chk("t1_cur_pid2", 64'(cur_pid), 64'd2);
        expect_sw(1, 32'h110);
        retire(QUANTUM, 32'h210);
        wait_req("t1_req3");
        ack();
        chk("t1_cur_pid1b", 64'(cur_pid), 64'd1);

        // 2. Lone process is redispatched through the handshake
        do_reset();
        expect_sw(3, 32'h300);
        create(3, 32'h300);
        wait_req("t2_req1");
        ack();
        expect_sw(3, 32'h33C);
        retire(QUANTUM, 32'h33C);
        wait_req("t2_req2");
        ack();
        retire(QUANTUM - 1, 32'h340);
        step(4);
        chk("t2_cnt_restart", 64'(sw_if.switch_req), 64'd0);
        expect_sw(3, 32'h344);
        retire(1, 32'h344);
        step(2);
        chk("t2_lat_req", 64'(sw_if.switch_req), 64'd1);
        ack();

        // 3. I/O block and wake
        do_reset();
        expect_sw(1, 32'h100);
        create(1, 32'h100);
        create(2, 32'h200);
        wait_req("t3_req1");
        ack();
        expect_sw(2, 32'h200);
        cur_pc = 32'h150;
        io_block = 1'b1;
        step(1);
        io_block = 1'b0;
        wait_req("t3_req2");
        chk("t3_mask_blk", 64'(ready_mask), 64'h04);
        ack();
        chk("t3_mask_run2", 64'(ready_mask), 64'h00);
        io_pid = 3'd1; io_done = 1'b1;
        step(1);
        io_done = 1'b0;
        chk("t3_wake", 64'(ready_mask), 64'h02);
        io_pid = 3'd5; io_done = 1'b1;
        step(1);
        io_done = 1'b0;
        chk("t3_wake_free", 64'(ready_mask), 64'h02);
        expect_sw(1, 32'h150);
        retire(QUANTUM, 32'h220);
        wait_req("t3_req3");
        ack();
        chk("t3_cur_pid1", 64'(cur_pid), 64'd1);

        // 4. Termination to idle, then a late create
        do_reset();
        expect_sw(4, 32'h400);
        create(4, 32'h400);
        wait_req("t4_req1");
        ack();
        chk("t4_idle_run", 64'(idle), 64'd0);
        proc_end = 1'b1;
        step(1);
        proc_end = 1'b0;
        chk("t4_idle_early", 64'(idle), 64'd0);
        step(1);
        chk("t4_idle", 64'(idle), 64'd1);
        chk("t4_no_req", 64'(sw_if.switch_req), 64'd0);
        step(3);
        chk("t4_no_req_late", 64'(sw_if.switch_req), 64'd0);
        expect_sw(0, 32'h40);
        create(0, 32'h40);
        wait_req("t4_req2");
        chk("t4_next_pc", 64'(sw_if.next_pc), 64'h40);
        ack();

        // 5. proc_end together with the expiring instruction
        do_reset();
        expect_sw(1, 32'h100);
        create(1, 32'h100);
        create(2, 32'h200);
        wait_req("t5_req1");
        ack();
        expect_sw(2, 32'h200);
        retire(QUANTUM - 1, 32'h120);
        cur_pc = 32'h124;
        instr_retired = 1'b1;
        proc_end = 1'b1;
        step(1);
        instr_retired = 1'b0;
        proc_end = 1'b0;
        chk("t5_lat_select", 64'(sw_if.switch_req), 64'd0);
        step(1);
        chk("t5_lat_req", 64'(sw_if.switch_req), 64'd1);
        ack();
        chk("t5_mask_free", 64'(ready_mask), 64'h00);
        expect_sw(2, 32'h230);
        retire(QUANTUM, 32'h230);
        wait_req("t5_req3");
        ack();
        chk("t5_cur_pid2", 64'(cur_pid), 64'd2);

        // 6. Asynchronous reset during REQ
        do_reset();
        expect_sw(3, 32'h300);
        create(3, 32'h300);
        wait_req("t6_req1");
        #6;
        reset = 1'b1;
        #1;
        chk("t6_async_req",  64'(sw_if.switch_req), 64'd0);
        chk("t6_next_pid",   64'(sw_if.next_pid),   64'd0);
        chk("t6_next_pc",    64'(sw_if.next_pc),    64'd0);
        chk("t6_cur_pid",    64'(cur_pid),          64'd0);
        chk("t6_idle",       64'(idle),             64'd1);
        chk("t6_ready_mask", 64'(ready_mask),       64'd0);
        step(1);
        reset = 1'b0;
        step(3);
        chk("t6_post_req",  64'(sw_if.switch_req), 64'd0);
        chk("t6_post_mask", 64'(ready_mask),       64'd0);

        step(2);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
